// File: rtl/subtractor_64_seq_if.sv
// Handshake and operand/result bundle for the sequential 64-bit subtractor.
interface subtractor_64_seq_if;
    logic        start;
    logic [63:0] A;
    logic [63:0] B;
    logic [63:0] out;
    logic        busy;
    logic        done;
    logic        borrow;
    logic        zero;
    logic        negative;
    logic        overflow;

    modport master (
        output start, A, B,
        input  out, busy, done, borrow, zero, negative, overflow
    );

    modport slave (
        input  start, A, B,
        output out, busy, done, borrow, zero, negative, overflow
    );
endinterface

// File: rtl/subtractor_64_seq.sv
// 64-bit A - B computed as A + ~B + 1, one 8-bit slice per clock over 8 cycles,
// with start/busy/done handshake and borrow/zero/negative/overflow flags.
module subtractor_64_seq (
    input  logic                  clk,
    input  logic                  reset,
    subtractor_64_seq_if.slave    bus
);

    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

    state_t      state;
    logic [2:0]  k;
    logic        carry;
    logic [63:0] a_reg;
    logic [63:0] b_reg;   // holds ~B so each slice is a plain add
    logic [63:0] acc;

    logic [7:0]  a_sl;
    logic [7:0]  b_sl;
    logic [8:0]  sum;
    logic [63:0] result;

    always_comb begin
        a_sl   = a_reg[{k, 3'b000} +: 8];
        b_sl   = b_reg[{k, 3'b000} +: 8];
        sum    = {1'b0, a_sl} + {1'b0, b_sl} + {8'b0, carry};
        // Only meaningful on the final slice, where the top byte is still pending.
        result = {sum[7:0], acc[55:0]};
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state        <= IDLE;
            k            <= '0;
            carry        <= 1'b0;
            a_reg        <= '0;
            b_reg        <= '0;
            acc          <= '0;
            bus.out      <= '0;
            bus.busy     <= 1'b0;
            bus.done     <= 1'b0;
            bus.borrow   <= 1'b0;
            bus.zero     <= 1'b0;
            bus.negative <= 1'b0;
            bus.overflow <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    bus.done <= 1'b0;
                    if (bus.start) begin
                        a_reg    <= bus.A;
                        b_reg    <= ~bus.B;
                        carry    <= 1'b1;
                        k        <= '0;
                        acc      <= '0;
                        bus.busy <= 1'b1;
                        state    <= RUN;
                    end
                end
                RUN: begin
                    acc[{k, 3'b000} +: 8] <= sum[7:0];
                    carry <= sum[8];
                    k     <= k + 3'd1;
                    if (k == 3'd7) begin
                        bus.out      <= result;
                        bus.borrow   <= ~sum[8];
                        bus.zero     <= (result == '0);
                        bus.negative <= result[63];
                        // b_reg is inverted, so equal top bits mean A and B signs differ.
                        bus.overflow <= (a_reg[63] == b_reg[63]) && (result[63] != a_reg[63]);
                        bus.busy     <= 1'b0;
                        bus.done     <= 1'b1;
                        state        <= DONE;
                    end
                end
                DONE: begin
                    bus.done <= 1'b0;
                    if (bus.start) begin
                        a_reg    <= bus.A;
                        b_reg    <= ~bus.B;
                        carry    <= 1'b1;
                        k        <= '0;
                        acc      <= '0;
                        bus.busy <= 1'b1;
                        state    <= RUN;
                    end else begin
                        state <= IDLE;
                    end
                end
                default: begin
                    state    <= IDLE;
                    bus.busy <= 1'b0;
                    bus.done <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: doc/subtractor_64_seq.md
# subtractor_64_seq

Multi-cycle 64-bit two's-complement subtractor computing out = A − B as A + ~B + 1, one 8-bit slice per clock over 8 cycles, with a start/busy/done handshake. It is the inverse-direction companion to the combinational 64-bit ripple adder in the ALU/address path. It serves ALU SUB/CMP and branch-compare operations where a short carry chain per cycle is preferred over a full 64-bit ripple. It also produces the condition flags.

## Interface
Parameters: none (width fixed at 64, slice fixed at 8 bits, 8 slices).

- clk  input  1  single clock; all state updates on rising edge
- reset  input  1  synchronous, active-high; sampled on rising edge of clk
- start  input  1  request; accepted only when busy = 0
- A  input  64  minuend; sampled only on the accepting edge
- B  input  64  subtrahend; sampled only on the accepting edge
- out  output  64  registered result A − B (mod 2^64); holds last completed value
- busy  output  1  high while a subtraction is in progress
- done  output  1  one-cycle pulse; out and flags are valid and newly updated
- borrow  output  1  1 when A < B unsigned (inverted final carry)
- zero  output  1  1 when result == 0
- negative  output  1  result[63]
- overflow  output  1  signed overflow: (A[63] ≠ B[63]) and (result[63] ≠ A[63])

## Operation
- States: IDLE, RUN, DONE.
- IDLE: busy = 0. On start = 1, latch A and ~B into internal operand registers, set carry = 1, set slice index k = 0, clear the internal accumulator, and go to RUN.
- RUN: busy = 1. Each edge computes {c, s} = A[8k+7:8k] + ~B[8k+7:8k] + carry as a 9-bit add, writes s into accumulator[8k+7:8k], sets carry = c, and increments k. On the edge where k == 7, copy accumulator with the final slice to out, update all four flags, and go to DONE.
- DONE: done = 1, busy = 0. On the next edge go to IDLE, or back to RUN if start = 1. In the RUN case, A and B are latched as in IDLE.
- start is ignored while busy = 1. Operand inputs may change freely after the accepting edge.
- out and flags change only on the completing edge. They are never partially updated during RUN.
- Flags: borrow = ~carry_final, zero = (result == 0), negative = result[63], overflow is as defined in Interface and uses the latched operand sign bits.
- Wrap-around: the result is modulo 2^64 and there is no saturation.

## Timing
- Reset values: out = 0, busy = 0, done = 0, borrow = 0, zero = 0, negative = 0, overflow = 0, state = IDLE, k = 0.
- Reset has priority over all other activity. Reset asserted mid-RUN aborts the operation: no done pulse, out and flags go to 0.
- Latency: start is accepted at edge E0. busy is high from after E0 through E8. out, flags, and done update at E8. done is high for exactly the one cycle between E8 and E9.
- Throughput: with start held high, a new operation is accepted at every DONE cycle. This gives one result every 9 cycles.
- start and reset asserted on the same edge: reset wins and start is dropped.

## Test plan
- Reset: assert reset for 2 cycles, then check all outputs = 0 and busy = 0. Then A = 4, B = 2, start for 1 cycle. Required: busy for 8 cycles, done pulse, out = 2, borrow = 0, zero = 0, negative = 0, overflow = 0.
- Borrow: A = 2, B = 4. Required: out = 64'hFFFF_FFFF_FFFF_FFFE, borrow = 1, negative = 1, overflow = 0, zero = 0.
- Signed overflow: A = 64'h8000_0000_0000_0000, B = 1. Required: out = 64'h7FFF_FFFF_FFFF_FFFF, overflow = 1, negative = 0, borrow = 0.
- Equal operands with cross-slice carry: A = B = 64'h0123_4567_89AB_CDEF. Required: out = 0, zero = 1, borrow = 0. Then A = 64'h1_0000_0000, B = 1 exercises borrow across 4 slices. Required: out = 64'hFFFF_FFFF, borrow = 0.
- Handshake:
  - Pulse start again during busy with different operands. Required: it is ignored, and the original result arrives at E8.
  - Hold start high through DONE. Required: the second operation starts immediately, with done pulses 9 cycles apart.
  - Change A and B after E0. Required: no effect on the result.
- Reset mid-operation: start A = 10, B = 3, then assert reset at E4. Required: no done pulse, all outputs = 0, and a subsequent A = 10, B = 3 yields out = 7 normally.
